// File: rtl/qif_spike_monitor_if.sv
// ISI stream from the spike monitor: FIFO head with a valid/ready handshake.
// The master drives data/valid and the slave drives ready.
interface qif_spike_monitor_if #(
  parameter int ISI_W = 16
);
  logic [ISI_W-1:0] isi_data;
  logic             isi_valid;
  logic             isi_ready;

  modport master (output isi_data, output isi_valid, input isi_ready);
  modport slave  (input isi_data, input isi_valid, output isi_ready);
endinterface

// File: rtl/qif_spike_monitor.sv
// Spike monitor: measures inter-spike intervals into a small FIFO and counts spikes per fixed window.
// Only rising edges of spike_in count, and all outputs are registered.
module qif_spike_monitor #(
  parameter int ISI_W      = 16,
  parameter int CNT_W      = 8,
  parameter int WIN_CYCLES = 1000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        spike_in,
  qif_spike_monitor_if.master         isi,
  output logic [CNT_W-1:0]            rate_count,
  output logic                        rate_valid,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = $clog2(WIN_CYCLES);
  localparam logic [WW-1:0] WIN_LAST = WW'(WIN_CYCLES - 1);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_ARMED} state_t;

  function automatic logic [ISI_W-1:0] isi_sat_inc(input logic [ISI_W-1:0] v);
    return (&v) ? v : v + ISI_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] cnt_sat_add(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && !(&v)) ? v + CNT_W'(1) : v;
  endfunction

  state_t           r_state, w_state_nxt;
  logic             r_spike_q;
  logic             w_edge, w_push, w_pop, w_full, w_wr_en;
  logic [ISI_W-1:0] r_isi_cnt, r_isi_data;
  logic [ISI_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr, w_rd_ptr_nxt;
  logic [AW:0]      r_level, w_level_nxt;
  logic             r_isi_valid;
  logic [WW-1:0]    r_win_cnt;
  logic [CNT_W-1:0] r_spk_cnt, r_rate_count;
  logic             r_rate_valid, r_overflow;

  assign w_edge       = spike_in & ~r_spike_q;
  assign w_push       = enable && w_edge && (r_state == S_ARMED);
  assign w_pop        = r_isi_valid && isi.isi_ready;
  assign w_full       = (r_level == FULL_LVL);
  assign w_wr_en      = w_push && (!w_full || w_pop);
  assign w_rd_ptr_nxt = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;

  always_comb begin
    w_state_nxt = r_state;
    if (!enable)
      w_state_nxt = S_IDLE;
    else if ((r_state == S_IDLE) && w_edge)
      w_state_nxt = S_ARMED;
  end

  always_comb begin
    w_level_nxt = r_level;
    case ({w_wr_en, w_pop})
      2'b10:   w_level_nxt = r_level + (AW + 1)'(1);
      2'b01:   w_level_nxt = r_level - (AW + 1)'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Edge detect, interval FSM and interval counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_spike_q <= 1'b0;
      r_state   <= S_IDLE;
      r_isi_cnt <= '0;
    end else begin
      r_spike_q <= spike_in;
      r_state   <= w_state_nxt;
      if (!enable)
        r_isi_cnt <= '0;
      else if (w_edge)
        r_isi_cnt <= ISI_W'(1);
      else if (r_state == S_ARMED)
        r_isi_cnt <= isi_sat_inc(r_isi_cnt);
    end
  end

  // FIFO storage and control
  always_ff @(posedge clk) begin
    if (w_wr_en)
      r_mem[r_wr_ptr] <= r_isi_cnt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_isi_valid <= 1'b0;
      r_isi_data  <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_wr_en)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_level     <= w_level_nxt;
      r_isi_valid <= (w_level_nxt != '0);
      // Head register sees the same-cycle write when the new head is the slot being written.
      if (w_level_nxt != '0)
        r_isi_data <= (w_wr_en && (w_rd_ptr_nxt == r_wr_ptr)) ? r_isi_cnt : r_mem[w_rd_ptr_nxt];
      if (w_push && w_full && !w_pop)
        r_overflow <= 1'b1;
    end
  end

  // Rate window; an edge on the last window cycle belongs to the ending window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_win_cnt    <= '0;
      r_spk_cnt    <= '0;
      r_rate_count <= '0;
      r_rate_valid <= 1'b0;
    end else begin
      r_rate_valid <= 1'b0;
      if (!enable) begin
        r_win_cnt <= '0;
        r_spk_cnt <= '0;
      end else if (r_win_cnt == WIN_LAST) begin
        r_win_cnt    <= '0;
        r_spk_cnt    <= '0;
        r_rate_count <= cnt_sat_add(r_spk_cnt, w_edge);
        r_rate_valid <= 1'b1;
      end else begin
        r_win_cnt <= r_win_cnt + WW'(1);
        r_spk_cnt <= cnt_sat_add(r_spk_cnt, w_edge);
      end
    end
  end

  assign isi.isi_data  = r_isi_data;
  assign isi.isi_valid = r_isi_valid;
  assign rate_count    = r_rate_count;
  assign rate_valid    = r_rate_valid;
  assign overflow      = r_overflow;
  assign fifo_level    = r_level;
endmodule
